// File: rtl/heavyhash_xor_pack_if.sv
// rtl/heavyhash_xor_pack_if.sv - hash, product-word and result handshakes of heavyhash_xor_pack
interface heavyhash_xor_pack_if #(
    parameter int HQ_DEPTH = 2
);
    localparam int CW = $clog2(HQ_DEPTH) + 1;

    logic          h_valid;
    logic          h_ready;
    logic [255:0]  h_data;
    logic          p_empty;
    logic          p_rd_en;
    logic [63:0]   p_dout;
    logic          r_valid;
    logic          r_ready;
    logic [255:0]  r_data;
    logic [CW-1:0] hq_count;

    modport master (
        output h_valid, h_data, p_empty, p_dout, r_ready,
        input  h_ready, p_rd_en, r_valid, r_data, hq_count
    );

    modport slave (
        input  h_valid, h_data, p_empty, p_dout, r_ready,
        output h_ready, p_rd_en, r_valid, r_data, hq_count
    );
endinterface

// File: rtl/heavyhash_xor_pack.sv
// rtl/heavyhash_xor_pack.sv - packs four 64-bit product words and XORs them with the queued Keccak hash
module heavyhash_xor_pack #(
    parameter int HQ_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    heavyhash_xor_pack_if.slave bus
);
    localparam int PW = $clog2(HQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t         state, state_nxt;
    logic [255:0]   hq_mem [HQ_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [1:0]     w;
    logic [191:0]   acc;
    logic [255:0]   r_data_q;
    logic           push, pop_word, pop_hash;

    // Full check uses the count alone so a same-cycle pop never frees a slot early.
    assign bus.h_ready  = !rst && (count < CW'(HQ_DEPTH));
    assign push         = bus.h_valid && bus.h_ready;
    assign bus.p_rd_en  = pop_word;
    assign bus.hq_count = count;
    assign bus.r_valid  = (state == HOLD);
    assign bus.r_data   = r_data_q;

    always_comb begin
        state_nxt = state;
        pop_word  = 1'b0;
        pop_hash  = 1'b0;
        case (state)
            COLLECT: begin
                // Never drain product words without a hash to pair them with.
                pop_word = !bus.p_empty && (count != '0);
                if (pop_word && w == 2'd3) begin
                    pop_hash  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.r_ready) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) hq_mem[wr_ptr] <= bus.h_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            w        <= '0;
            acc      <= '0;
            r_data_q <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (pop_hash) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_hash})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop_word) begin
                w <= w + 2'd1;
                // The last word goes straight into the result; acc holds only words 0..2.
                case (w)
                    2'd0:    acc[191:128] <= bus.p_dout;
                    2'd1:    acc[127:64]  <= bus.p_dout;
                    2'd2:    acc[63:0]    <= bus.p_dout;
                    default: r_data_q     <= {acc, bus.p_dout} ^ hq_mem[rd_ptr];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_heavyhash_xor_pack.sv
// tb/tb_heavyhash_xor_pack.sv - scoreboard bench for heavyhash_xor_pack
module tb_heavyhash_xor_pack;
    localparam int HQ_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    heavyhash_xor_pack_if #(.HQ_DEPTH(HQ_DEPTH)) bus ();

    heavyhash_xor_pack #(.HQ_DEPTH(HQ_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0]  wmem [0:255];
    int           wcnt = 0;
    int           prd  = 0;
    int           cyc  = 0;
    logic [255:0] exp_q [$];
    int           acc_times [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    assign bus.p_empty = (prd >= wcnt);
    assign bus.p_dout  = wmem[prd[7:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.p_rd_en && !bus.p_empty) prd <= prd + 1;
    end

    always @(negedge clk) begin
        if (!rst && bus.r_valid && bus.r_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got %h, required no result", bus.r_data);
            end else begin
                logic [255:0] e;
                e = exp_q.pop_front();
                if (bus.r_data !== e) begin
                    n_fail++;
                    $display("FAIL result_data: got %h, required %h", bus.r_data, e);
                end
            end
            acc_times.push_back(cyc);
        end
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic add_words(input logic [255:0] v);
        for (int i = 0; i < 4; i++) begin
            wmem[wcnt[7:0]] = v[255 - 64*i -: 64];
            wcnt++;
        end
    endtask

    task automatic push_hash(input logic [255:0] h);
        int t;
        @(negedge clk);
        bus.h_valid = 1'b1;
        bus.h_data  = h;
        t = 0;
        while (!bus.h_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!bus.h_ready) begin
            n_fail++;
            $display("FAIL hash_push_timeout: h_ready=%b, required 1", bus.h_ready);
        end
        @(posedge clk);
        #1 bus.h_valid = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int t;
        t = 0;
        while (acc_times.size() < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (acc_times.size() < target) begin
            n_fail++;
            $display("FAIL result_timeout: got %0d results, required %0d", acc_times.size(), target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (bus.h_ready !== 1'b0) begin n_fail++; $display("FAIL reset_h_ready: got %b, required 0", bus.h_ready); end
        if (bus.p_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_p_rd_en: got %b, required 0", bus.p_rd_en); end
        if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid: got %b, required 0", bus.r_valid); end
        if (bus.r_data !== 256'h0) begin n_fail++; $display("FAIL reset_r_data: got %h, required 0", bus.r_data); end
        if (bus.hq_count !== 2'd0) begin n_fail++; $display("FAIL reset_hq_count: got %0d, required 0", bus.hq_count); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.h_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_h_ready: got %b, required 1", bus.h_ready); end
    endtask

    task automatic test_single();
        int base, highs;
        base = acc_times.size();
        exp_q.push_back(256'h0123456789ABCDEF_FEDCBA9876543210_0000000000000000_FFFFFFFFFFFFFFFF);
        @(negedge clk);
        add_words(256'h0123456789ABCDEF_FEDCBA9876543210_0000000000000000_FFFFFFFFFFFFFFFF);
        push_hash(256'h0);
        highs = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.r_valid) highs++;
        end
        n_checks++;
        if (highs != 1) begin n_fail++; $display("FAIL single_pulse_width: got %0d cycles, required 1", highs); end
        wait_results(base + 1);
    endtask

    task automatic test_xor();
        int base;
        base = acc_times.size();
        exp_q.push_back({64{4'h5}});
        @(negedge clk);
        add_words({4{64'hAAAA_AAAA_AAAA_AAAA}});
        push_hash({256{1'b1}});
        wait_results(base + 1);
    endtask

    task automatic test_orphan();
        int base, bad;
        logic [255:0] h, v;
        base = acc_times.size();
        h = rand256();
        v = rand256();
        exp_q.push_back(v ^ h);
        @(negedge clk);
        add_words(v);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.p_rd_en !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL orphan_stall: got %0d read cycles, required 0", bad); end
        push_hash(h);
        @(negedge clk);
        n_checks++;
        if (bus.p_rd_en !== 1'b1) begin n_fail++; $display("FAIL orphan_rd_en_after_push: got %b, required 1", bus.p_rd_en); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL orphan_early_result: got %b, required 0", bus.r_valid); end
        @(negedge clk);
        n_checks++;
        if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL orphan_latency: r_valid=%b, required 1", bus.r_valid); end
        wait_results(base + 1);
    endtask

    task automatic test_backpressure();
        int base, t, bad;
        logic [255:0] h1, h2, v1, v2;
        base = acc_times.size();
        h1 = rand256(); h2 = rand256(); v1 = rand256(); v2 = rand256();
        exp_q.push_back(v1 ^ h1);
        exp_q.push_back(v2 ^ h2);
        @(negedge clk);
        bus.r_ready = 1'b0;
        add_words(v1);
        add_words(v2);
        push_hash(h1);
        push_hash(h2);
        t = 0;
        while (!bus.r_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!bus.r_valid) begin n_fail++; $display("FAIL bp_no_result: r_valid=%b, required 1", bus.r_valid); end
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.r_valid !== 1'b1 || bus.r_data !== (v1 ^ h1) || bus.p_rd_en !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d unstable cycles, required 0", bad); end
        n_checks++;
        if (wcnt - prd != 4) begin n_fail++; $display("FAIL bp_words_pending: got %0d, required 4", wcnt - prd); end
        bus.r_ready = 1'b1;
        wait_results(base + 2);
        n_checks++;
        if (wcnt != prd) begin n_fail++; $display("FAIL bp_words_lost: got %0d unread, required 0", wcnt - prd); end
    endtask

    task automatic test_queue_full();
        int base, t, bad;
        logic [255:0] h1, h2, h3, v1, v2, v3;
        base = acc_times.size();
        h1 = rand256(); h2 = rand256(); h3 = rand256();
        v1 = rand256(); v2 = rand256(); v3 = rand256();
        exp_q.push_back(v1 ^ h1);
        exp_q.push_back(v2 ^ h2);
        exp_q.push_back(v3 ^ h3);
        push_hash(h1);
        push_hash(h2);
        @(negedge clk);
        n_checks += 2;
        if (bus.h_ready !== 1'b0) begin n_fail++; $display("FAIL full_h_ready: got %b, required 0", bus.h_ready); end
        if (bus.hq_count !== 2'd2) begin n_fail++; $display("FAIL full_hq_count: got %0d, required 2", bus.hq_count); end
        bus.h_valid = 1'b1;
        bus.h_data  = h3;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.h_ready !== 1'b0 || bus.hq_count !== 2'd2) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL full_third_blocked: got %0d accepting cycles, required 0", bad); end
        add_words(v1);
        t = 0;
        while (!bus.h_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks += 2;
        if (bus.h_ready !== 1'b1) begin n_fail++; $display("FAIL full_third_accept: h_ready=%b, required 1", bus.h_ready); end
        if (bus.r_valid !== 1'b1) begin n_fail++; $display("FAIL full_accept_order: r_valid=%b, required 1", bus.r_valid); end
        @(posedge clk);
        #1 bus.h_valid = 1'b0;
        add_words(v2);
        add_words(v3);
        wait_results(base + 3);
        @(negedge clk);
        n_checks++;
        if (bus.hq_count !== 2'd0) begin n_fail++; $display("FAIL full_drained: got %0d, required 0", bus.hq_count); end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [255:0] h [3];
        logic [255:0] v [3];
        base = acc_times.size();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            h[i] = rand256();
            v[i] = rand256();
            exp_q.push_back(v[i] ^ h[i]);
            add_words(v[i]);
        end
        for (int i = 0; i < 3; i++) push_hash(h[i]);
        wait_results(base + 3);
        if (acc_times.size() >= base + 3) begin
            n_checks += 2;
            if (acc_times[base+1] - acc_times[base] != 5) begin
                n_fail++; $display("FAIL b2b_interval_1: got %0d cycles, required 5", acc_times[base+1] - acc_times[base]);
            end
            if (acc_times[base+2] - acc_times[base+1] != 5) begin
                n_fail++; $display("FAIL b2b_interval_2: got %0d cycles, required 5", acc_times[base+2] - acc_times[base+1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, t;
        logic [255:0] h, v;
        base = acc_times.size();
        @(negedge clk);
        wmem[wcnt[7:0]] = 64'hDEAD_BEEF_0BAD_F00D; wcnt++;
        wmem[wcnt[7:0]] = 64'h1357_9BDF_2468_ACE0; wcnt++;
        push_hash(rand256());
        t = 0;
        while (prd != wcnt && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (prd != wcnt) begin n_fail++; $display("FAIL mid_words_consumed: got %0d unread, required 0", wcnt - prd); end
        rst = 1'b1;
        @(negedge clk);
        n_checks += 5;
        if (bus.h_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_h_ready: got %b, required 0", bus.h_ready); end
        if (bus.p_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_p_rd_en: got %b, required 0", bus.p_rd_en); end
        if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_r_valid: got %b, required 0", bus.r_valid); end
        if (bus.r_data !== 256'h0) begin n_fail++; $display("FAIL mid_reset_r_data: got %h, required 0", bus.r_data); end
        if (bus.hq_count !== 2'd0) begin n_fail++; $display("FAIL mid_reset_hq_count: got %0d, required 0", bus.hq_count); end
        rst = 1'b0;
        h = rand256();
        v = rand256();
        exp_q.push_back(v ^ h);
        add_words(v);
        push_hash(h);
        wait_results(base + 1);
    endtask

    initial begin
        bus.h_valid = 1'b0;
        bus.h_data  = '0;
        bus.r_ready = 1'b1;
        test_reset();
        test_single();
        test_xor();
        test_orphan();
        test_backpressure();
        test_queue_full();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
